tl_phase_sequencer: RTL

Sequential back end of the traffic-light controller. Each cycle it supplies the combinational next-state logic with synchronized sensor inputs and receives the proposed next state `nxt_s` in return. It holds the current phase for a programmed dwell time, then commits `nxt_s`. It drives the registered 3-bit state and the decoded lamp outputs for street A and street B.

---
 rtl/tl_pkg.sv | 33 +++
 rtl/tl_tick_gen.sv | 20 ++
 rtl/tl_phase_sequencer.sv | 92 +++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: shared state codes, lamp encodings and dwell classification for the traffic-light sequencer.
package tl_pkg;
  typedef enum logic [2:0] {
    ST_A_GREEN   = 3'b000,
    ST_A_YELLOW  = 3'b001,
    ST_CLEAR_AB  = 3'b010,
    ST_CLEAR_AB2 = 3'b011,
    ST_B_GREEN   = 3'b100,
    ST_B_YELLOW  = 3'b101,
    ST_CLEAR_BA  = 3'b110,
    ST_CLEAR_BA2 = 3'b111
  } tlState_t;

  typedef enum logic [1:0] {DW_GREEN, DW_YELLOW, DW_CLEAR} dwellClass_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Bit 1 marks every all-red code; bit 0 separates yellow from green.
  function automatic dwellClass_t dwellSel(input logic [2:0] st);
    return st[1] ? DW_CLEAR : st[0] ? DW_YELLOW : DW_GREEN;
  endfunction

  function automatic logic [2:0] lampA(input logic [2:0] st);
    return st == ST_A_GREEN ? LAMP_G : st == ST_A_YELLOW ? LAMP_Y : LAMP_R;
  endfunction

  function automatic logic [2:0] lampB(input logic [2:0] st);
    return st == ST_B_GREEN ? LAMP_G : st == ST_B_YELLOW ? LAMP_Y : LAMP_R;
  endfunction
endpackage

// File: rtl/tl_tick_gen.sv
// tl_tick_gen: prescaler counting 0..TICK_DIV-1, one-cycle tick at the top, synchronous clear.
module tl_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = cnt == LAST;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/tl_phase_sequencer.sv
// tl_phase_sequencer: phase register, dwell timing, sensor sync and lamp decode for the traffic light.
// Optional maintenance flash mode is built when TL_FLASH_EN is defined.
module tl_phase_sequencer
  import tl_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int CLEAR_T  = 1
) (
`ifdef TL_FLASH_EN
  input  logic       flash,
`endif
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sA,
  input  logic       sB,
  input  logic [2:0] nxt_s,
  output logic [2:0] s,
  output logic       sa_sync,
  output logic       sb_sync,
  output logic [2:0] lamp_a,
  output logic [2:0] lamp_b
);
  logic       tick, tickClr, commit, saMeta, sbMeta;
  logic [7:0] dwellCnt;

  function automatic logic [7:0] dwellLoad(input logic [2:0] st);
    return dwellSel(st) == DW_GREEN  ? 8'(GREEN_T - 1) :
           dwellSel(st) == DW_YELLOW ? 8'(YELLOW_T - 1) : 8'(CLEAR_T - 1);
  endfunction

  assign commit = tick && dwellCnt == 8'd0;

`ifdef TL_FLASH_EN
  logic flashPrev, flashEnd;
  assign flashEnd = flashPrev && !flash;
  assign tickClr  = commit || flashEnd;
`else
  assign tickClr  = commit;
`endif

  tl_tick_gen #(.TICK_DIV(TICK_DIV)) uTick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tickClr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      saMeta  <= 1'b0;
      sbMeta  <= 1'b0;
      sa_sync <= 1'b0;
      sb_sync <= 1'b0;
    end else begin
      saMeta  <= sA;
      sbMeta  <= sB;
      sa_sync <= saMeta;
      sb_sync <= sbMeta;
    end

  // Lamps are loaded from the decode of the value entering s, so they never lag it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s        <= ST_A_GREEN;
      lamp_a   <= LAMP_G;
      lamp_b   <= LAMP_R;
      dwellCnt <= 8'(GREEN_T - 1);
`ifdef TL_FLASH_EN
      flashPrev <= 1'b0;
`endif
    end else begin
`ifdef TL_FLASH_EN
      flashPrev <= flash;
      if (flash) begin
        lamp_a <= !flashPrev ? LAMP_Y : tick ? (lamp_a == LAMP_Y ? LAMP_OFF : LAMP_Y) : lamp_a;
        lamp_b <= !flashPrev ? LAMP_Y : tick ? (lamp_b == LAMP_Y ? LAMP_OFF : LAMP_Y) : lamp_b;
      end else if (flashEnd) begin
        lamp_a   <= lampA(s);
        lamp_b   <= lampB(s);
        dwellCnt <= dwellLoad(s);
      end else
`endif
      if (commit) begin
        s        <= nxt_s;
        lamp_a   <= lampA(nxt_s);
        lamp_b   <= lampB(nxt_s);
        dwellCnt <= dwellLoad(nxt_s);
      end else if (tick) dwellCnt <= dwellCnt - 8'd1;
    end
endmodule
